// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Handles load-use bubbles, branch flushes, data-memory freezes, the ecall
// drain-then-halt sequence and the memory-timeout error halt.
// Optional macro HAZARD_PERF_CNT_EN enables the stall/flush performance counters;
// when it is undefined both counters read 0 and no counter flops exist.
module pipe_hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       d_opcode,
   input  logic [4:0]       d_rs1_index,
   input  logic [4:0]       d_rs2_index,
   input  logic [4:0]       e_opcode,
   input  logic [4:0]       e_rd_index,
   input  logic             e_wb_en,
   input  logic             e_jb_taken,
   input  logic             e_ecall,
   input  logic             m_mem_req,
   input  logic             dm_ready,
   output logic             stall_pc,
   output logic             stall_fd,
   output logic             stall_de,
   output logic             stall_em,
   output logic             stall_mw,
   output logic             flush_fd,
   output logic             flush_de,
   output logic             halt,
   output logic             mem_err,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt
);

   localparam int unsigned WAIT_W  = (MEM_TIMEOUT  < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_STORE  = 5'b01000;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_DRAIN    = 2'd2,
      S_HALT     = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic [DRAIN_W-1:0]  drain_cnt, drain_nxt;
   logic                halt_nxt, err_nxt;
   logic                rs1_used, rs2_used, load_use, mem_block;
   logic                run_path;

   // Operand usage of the D instruction and the two hazard conditions
   always_comb begin
      rs1_used  = !((d_opcode == OPC_LUI) || (d_opcode == OPC_AUIPC) || (d_opcode == OPC_JAL));
      rs2_used  = (d_opcode == OPC_OP) || (d_opcode == OPC_STORE) || (d_opcode == OPC_BRANCH);
      load_use  = (e_opcode == OPC_LOAD) && e_wb_en && (e_rd_index != 5'd0) &&
                  ((rs1_used && (d_rs1_index == e_rd_index)) ||
                   (rs2_used && (d_rs2_index == e_rd_index)));
      mem_block = m_mem_req && !dm_ready;
   end

   // Next-state and same-cycle stall/flush decode
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      drain_nxt = drain_cnt;
      halt_nxt  = halt;
      err_nxt   = mem_err;
      run_path  = 1'b0;
      stall_pc  = 1'b0;
      stall_fd  = 1'b0;
      stall_de  = 1'b0;
      stall_em  = 1'b0;
      stall_mw  = 1'b0;
      flush_fd  = 1'b0;
      flush_de  = 1'b0;

      case (state)
         S_RUN: run_path = 1'b1;
         S_MEM_WAIT: begin
            if (!dm_ready) begin
               {stall_pc, stall_fd, stall_de, stall_em, stall_mw} = 5'b11111;
               if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                  state_nxt = S_HALT;
                  halt_nxt  = 1'b1;
                  err_nxt   = 1'b1;
               end else begin
                  wait_nxt = wait_cnt + WAIT_W'(1);
               end
            end else begin
               run_path = 1'b1;
            end
         end
         S_DRAIN: begin
            stall_pc = 1'b1;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            if (mem_block) begin
               stall_em = 1'b1;
               stall_mw = 1'b1;
            end else if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
               state_nxt = S_HALT;
               halt_nxt  = 1'b1;
            end else begin
               drain_nxt = drain_cnt + DRAIN_W'(1);
            end
         end
         default: begin
            stall_pc = 1'b1;
            flush_fd = 1'b1;
            flush_de = 1'b1;
         end
      endcase

      // Normal issue priorities; also taken on the MEM_WAIT release cycle
      if (run_path) begin
         state_nxt = S_RUN;
         wait_nxt  = '0;
         if (mem_block) begin
            {stall_pc, stall_fd, stall_de, stall_em, stall_mw} = 5'b11111;
            state_nxt = S_MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
         end else if (e_ecall) begin
            stall_pc  = 1'b1;
            flush_fd  = 1'b1;
            flush_de  = 1'b1;
            state_nxt = S_DRAIN;
            drain_nxt = '0;
         end else if (e_jb_taken) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
         end else if (load_use) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            flush_de = 1'b1;
         end
      end

      // Reset silences every control line at once
      if (!rst) begin
         {stall_pc, stall_fd, stall_de, stall_em, stall_mw} = 5'b00000;
         flush_fd = 1'b0;
         flush_de = 1'b0;
      end
   end

   // State, counters and sticky halt/error flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_RUN;
         wait_cnt  <= '0;
         drain_cnt <= '0;
         halt      <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_nxt;
         drain_cnt <= drain_nxt;
         halt      <= halt_nxt;
         mem_err   <= err_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Stall/flush cycle counters, frozen once halted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else if (state != S_HALT) begin
         if (stall_pc) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
         if (flush_de) perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
   end
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each task queues its expected
// control vector with the stimulus and checks it once the outputs settle.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W = 32;

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_STORE  = 5'b01000;

   // {stall_pc, stall_fd, stall_de, stall_em, stall_mw, flush_fd, flush_de, halt, mem_err}
   localparam logic [8:0] O_NONE = 9'b000000000;
   localparam logic [8:0] O_LU   = 9'b110000100;
   localparam logic [8:0] O_JB   = 9'b000001100;
   localparam logic [8:0] O_FRZ  = 9'b111110000;
   localparam logic [8:0] O_DR   = 9'b100001100;
   localparam logic [8:0] O_DRMB = 9'b100111100;
   localparam logic [8:0] O_HALT = 9'b100001110;
   localparam logic [8:0] O_HERR = 9'b100001111;

   typedef struct packed {
      logic       rstv;
      logic [4:0] d_op;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] e_op;
      logic [4:0] e_rd;
      logic       wb;
      logic       jb;
      logic       ec;
      logic       mreq;
      logic       dmr;
   } stim_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [4:0]       d_opcode = 5'd0, d_rs1_index = 5'd0, d_rs2_index = 5'd0;
   logic [4:0]       e_opcode = 5'd0, e_rd_index = 5'd0;
   logic             e_wb_en = 1'b0, e_jb_taken = 1'b0, e_ecall = 1'b0;
   logic             m_mem_req = 1'b0, dm_ready = 1'b1;
   logic             stall_pc, stall_fd, stall_de, stall_em, stall_mw;
   logic             flush_fd, flush_de, halt, mem_err;
   logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;
   logic [8:0]       obs;

   logic [8:0] sb_q[$];
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .DRAIN_CYCLES(3),
      .MEM_TIMEOUT (16),
      .CNT_W       (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .d_opcode      (d_opcode),
      .d_rs1_index   (d_rs1_index),
      .d_rs2_index   (d_rs2_index),
      .e_opcode      (e_opcode),
      .e_rd_index    (e_rd_index),
      .e_wb_en       (e_wb_en),
      .e_jb_taken    (e_jb_taken),
      .e_ecall       (e_ecall),
      .m_mem_req     (m_mem_req),
      .dm_ready      (dm_ready),
      .stall_pc      (stall_pc),
      .stall_fd      (stall_fd),
      .stall_de      (stall_de),
      .stall_em      (stall_em),
      .stall_mw      (stall_mw),
      .flush_fd      (flush_fd),
      .flush_de      (flush_de),
      .halt          (halt),
      .mem_err       (mem_err),
      .perf_stall_cnt(perf_stall_cnt),
      .perf_flush_cnt(perf_flush_cnt)
   );

   assign obs = {stall_pc, stall_fd, stall_de, stall_em, stall_mw, flush_fd, flush_de, halt, mem_err};

   function automatic stim_t st_idle();
      stim_t s;
      s      = '0;
      s.rstv = 1'b1;
      s.d_op = OPC_LUI;
      s.e_op = OPC_OP;
      s.dmr  = 1'b1;
      return s;
   endfunction

   function automatic stim_t st_rst();
      stim_t s;
      s      = st_idle();
      s.rstv = 1'b0;
      return s;
   endfunction

   // Load in E writing e_rd, arbitrary instruction in D
   function automatic stim_t st_lu(input logic [4:0] dop, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [4:0] erd, input logic wb);
      stim_t s;
      s      = st_idle();
      s.d_op = dop;
      s.rs1  = r1;
      s.rs2  = r2;
      s.e_op = OPC_LOAD;
      s.e_rd = erd;
      s.wb   = wb;
      return s;
   endfunction

   function automatic stim_t st_blk();
      stim_t s;
      s      = st_idle();
      s.mreq = 1'b1;
      s.dmr  = 1'b0;
      return s;
   endfunction

   function automatic stim_t st_ec();
      stim_t s;
      s    = st_idle();
      s.ec = 1'b1;
      return s;
   endfunction

   function automatic stim_t st_jb();
      stim_t s;
      s    = st_idle();
      s.jb = 1'b1;
      return s;
   endfunction

   // Queue the expectation, drive at the falling edge, let outputs settle
   task automatic apply(input stim_t s, input logic [8:0] e);
      sb_q.push_back(e);
      @(negedge clk);
      rst         = s.rstv;
      d_opcode    = s.d_op;
      d_rs1_index = s.rs1;
      d_rs2_index = s.rs2;
      e_opcode    = s.e_op;
      e_rd_index  = s.e_rd;
      e_wb_en     = s.wb;
      e_jb_taken  = s.jb;
      e_ecall     = s.ec;
      m_mem_req   = s.mreq;
      dm_ready    = s.dmr;
      #2;
   endtask

   task automatic test_reset();
      logic [8:0] ev;
      apply(st_rst(), O_NONE);
      ev = sb_q.pop_front();
      vectors++;
      if (obs !== ev) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected %b", obs, ev);
      end
      vectors++;
      if (perf_stall_cnt !== '0 || perf_flush_cnt !== '0) begin
         miscompares++;
         $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
      end
   endtask

   task automatic test_load_use();
      stim_t st[$];
      logic [8:0] ex[$];
      logic [8:0] ev;
      st.push_back(st_rst());                        ex.push_back(O_NONE);
      st.push_back(st_lu(OPC_OP, 5, 1, 5, 1));       ex.push_back(O_LU);
      st.push_back(st_idle());                       ex.push_back(O_NONE);
      st.push_back(st_lu(OPC_OP, 1, 5, 5, 1));       ex.push_back(O_LU);
      st.push_back(st_lu(OPC_OP, 0, 0, 0, 1));       ex.push_back(O_NONE);
      st.push_back(st_lu(OPC_OP, 5, 1, 5, 0));       ex.push_back(O_NONE);
      st.push_back(st_lu(OPC_LUI, 5, 5, 5, 1));      ex.push_back(O_NONE);
      st.push_back(st_lu(OPC_STORE, 1, 5, 5, 1));    ex.push_back(O_LU);
      st.push_back(st_lu(OPC_JALR, 1, 5, 5, 1));     ex.push_back(O_NONE);
      st.push_back(st_lu(OPC_BRANCH, 7, 2, 7, 1));   ex.push_back(O_LU);
      st.push_back(st_idle());                       ex.push_back(O_NONE);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL load_use[%0d]: got %b expected %b", i, obs, ev);
         end
      end
   endtask

   task automatic test_jb_vs_load_use();
      stim_t st[$];
      logic [8:0] ex[$];
      logic [8:0] ev;
      stim_t s;
      s    = st_lu(OPC_OP, 5, 1, 5, 1);
      s.jb = 1'b1;
      st.push_back(st_rst());   ex.push_back(O_NONE);
      st.push_back(s);          ex.push_back(O_JB);
      st.push_back(st_idle());  ex.push_back(O_NONE);
      st.push_back(st_jb());    ex.push_back(O_JB);
      st.push_back(st_idle());  ex.push_back(O_NONE);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL jb_vs_load_use[%0d]: got %b expected %b", i, obs, ev);
         end
      end
   endtask

   task automatic test_mem_wait();
      stim_t st[$];
      logic [8:0] ex[$];
      logic [8:0] ev;
      stim_t rdy, rdy_ec;
      rdy       = st_idle();
      rdy.mreq  = 1'b1;
      rdy_ec    = rdy;
      rdy_ec.ec = 1'b1;
      st.push_back(st_rst());   ex.push_back(O_NONE);
      for (int k = 0; k < 4; k++) begin
         st.push_back(st_blk()); ex.push_back(O_FRZ);
      end
      st.push_back(rdy);        ex.push_back(O_NONE);
      st.push_back(st_idle());  ex.push_back(O_NONE);
      st.push_back(st_lu(OPC_OP, 5, 1, 5, 1)); ex.push_back(O_LU);
      // Release cycle carrying an ecall goes straight into the drain
      st.push_back(st_blk());   ex.push_back(O_FRZ);
      st.push_back(rdy_ec);     ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_HALT);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL mem_wait[%0d]: got %b expected %b", i, obs, ev);
         end
      end
   endtask

   task automatic test_ecall_drain();
      stim_t st[$];
      logic [8:0] ex[$];
      logic [8:0] ev;
      stim_t ec_jb, dr_lu;
      ec_jb    = st_ec();
      ec_jb.jb = 1'b1;
      dr_lu    = st_lu(OPC_OP, 5, 1, 5, 1);
      dr_lu.jb = 1'b1;
      st.push_back(st_rst());   ex.push_back(O_NONE);
      st.push_back(ec_jb);      ex.push_back(O_DR);
      st.push_back(dr_lu);      ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_HALT);
      st.push_back(st_jb());    ex.push_back(O_HALT);
      st.push_back(st_blk());   ex.push_back(O_HALT);
      st.push_back(st_idle());  ex.push_back(O_HALT);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL ecall_drain[%0d]: got %b expected %b", i, obs, ev);
         end
      end
   endtask

   task automatic test_drain_mem_block();
      stim_t st[$];
      logic [8:0] ex[$];
      logic [8:0] ev;
      st.push_back(st_rst());   ex.push_back(O_NONE);
      st.push_back(st_ec());    ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(st_blk());   ex.push_back(O_DRMB);
      st.push_back(st_blk());   ex.push_back(O_DRMB);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_HALT);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL drain_mem_block[%0d]: got %b expected %b", i, obs, ev);
         end
      end
   endtask

   task automatic test_timeout();
      stim_t st[$];
      logic [8:0] ex[$];
      logic [8:0] ev;
      st.push_back(st_rst());   ex.push_back(O_NONE);
      for (int k = 0; k < 16; k++) begin
         st.push_back(st_blk()); ex.push_back(O_FRZ);
      end
      st.push_back(st_idle());  ex.push_back(O_HERR);
      st.push_back(st_jb());    ex.push_back(O_HERR);
      st.push_back(st_ec());    ex.push_back(O_HERR);
      st.push_back(st_idle());  ex.push_back(O_HERR);
      st.push_back(st_rst());   ex.push_back(O_NONE);
      st.push_back(st_idle());  ex.push_back(O_NONE);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL timeout[%0d]: got %b expected %b", i, obs, ev);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t st[$];
      logic [8:0] ex[$];
      logic [8:0] ev;
      stim_t rst_blk;
      rst_blk      = st_blk();
      rst_blk.rstv = 1'b0;
      st.push_back(st_rst());   ex.push_back(O_NONE);
      st.push_back(st_ec());    ex.push_back(O_DR);
      st.push_back(st_idle());  ex.push_back(O_DR);
      st.push_back(rst_blk);    ex.push_back(O_NONE);
      for (int k = 0; k < 4; k++) begin
         st.push_back(st_idle()); ex.push_back(O_NONE);
      end
      st.push_back(st_blk());   ex.push_back(O_FRZ);
      st.push_back(st_blk());   ex.push_back(O_FRZ);
      st.push_back(rst_blk);    ex.push_back(O_NONE);
      st.push_back(st_idle());  ex.push_back(O_NONE);
      st.push_back(st_blk());   ex.push_back(O_FRZ);
      st.push_back(st_idle());  ex.push_back(O_NONE);
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i], ex[i]);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL reset_mid[%0d]: got %b expected %b", i, obs, ev);
         end
      end
   endtask

   task automatic test_perf();
      logic [8:0] ev;
      int exp_stall, exp_flush;
`ifdef HAZARD_PERF_CNT_EN
      exp_stall = 5;
      exp_flush = 6;
`else
      exp_stall = 0;
      exp_flush = 0;
`endif
      apply(st_rst(), O_NONE);
      ev = sb_q.pop_front();
      vectors++;
      if (obs !== ev) begin
         miscompares++;
         $display("FAIL perf_reset: got %b expected %b", obs, ev);
      end
      for (int k = 0; k < 5; k++) begin
         apply(st_lu(OPC_OP, 5, 1, 5, 1), O_LU);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL perf_lu[%0d]: got %b expected %b", k, obs, ev);
         end
         apply(st_idle(), O_NONE);
         ev = sb_q.pop_front();
         vectors++;
         if (obs !== ev) begin
            miscompares++;
            $display("FAIL perf_idle[%0d]: got %b expected %b", k, obs, ev);
         end
      end
      apply(st_jb(), O_JB);
      ev = sb_q.pop_front();
      vectors++;
      if (obs !== ev) begin
         miscompares++;
         $display("FAIL perf_jb: got %b expected %b", obs, ev);
      end
      apply(st_idle(), O_NONE);
      ev = sb_q.pop_front();
      vectors++;
      if (perf_stall_cnt !== CNT_W'(exp_stall)) begin
         miscompares++;
         $display("FAIL perf_stall_cnt: got %0d expected %0d", perf_stall_cnt, exp_stall);
      end
      vectors++;
      if (perf_flush_cnt !== CNT_W'(exp_flush)) begin
         miscompares++;
         $display("FAIL perf_flush_cnt: got %0d expected %0d", perf_flush_cnt, exp_flush);
      end
      vectors++;
      if (obs !== ev) begin
         miscompares++;
         $display("FAIL perf_final: got %b expected %b", obs, ev);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_jb_vs_load_use();
      test_mem_wait();
      test_ecall_drain();
      test_drain_mem_block();
      test_timeout();
      test_reset_mid();
      test_perf();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
